// File: rtl/uart_receiver_pkg.sv
// Shared UART receive definitions: FSM state encoding and 8N1 frame constants.
// The cycles-per-bit constant is also used by the transmitter instance.
package uart_receiver_pkg;

    localparam int UART_CLK_CYCLES_115200 = 87;
    localparam int DATA_BITS              = 8;
    localparam int STOP_BITS              = 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } rx_state_e;

endpackage

// File: rtl/uart_receiver_if.sv
// Byte-wide valid/ready stream between the UART receiver and its consumer.
// master = producer side (receiver), slave = consumer side.
interface uart_receiver_if;
    import uart_receiver_pkg::*;

    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 ready;

    modport master (
        output data,
        output valid,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        output ready
    );

endinterface

// File: rtl/uart_bit_timer.sv
// Loadable down-counter with a level expiry strobe while the count sits at zero.
// Parameterised by width so the transmitter can share it.
module uart_bit_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         expired_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Parks at zero instead of wrapping; only a load moves it away.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling FSM, and a one-entry
// valid/ready holding register with framing-error and overrun pulses.
module uart_receiver
    import uart_receiver_pkg::*;
#(
    parameter int CLK_CYCLES  = UART_CLK_CYCLES_115200,
    parameter int HALF_CYCLES = CLK_CYCLES / 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             uart_rx,
    uart_receiver_if.master  rx_if,
    output logic             frame_err,
    output logic             overrun
);

    localparam int CNT_W = $clog2(CLK_CYCLES);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF_CYCLES - 1);
    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLK_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);

    // Both flops reset to the idle level so reset release cannot look like a start bit.
    logic rx_meta_q;
    logic rx_s_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    rx_state_e            state_q,     state_d;
    logic [IDX_W-1:0]     bit_idx_q,   bit_idx_d;
    logic [DATA_BITS-1:0] shift_q,     shift_d;
    logic                 commit_q,    commit_d;
    logic                 frame_err_q, frame_err_d;
    logic [DATA_BITS-1:0] data_q,      data_d;
    logic                 valid_q,     valid_d;
    logic                 overrun_q,   overrun_d;

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_exp;

    uart_bit_timer #(
        .W (CNT_W)
    ) u_bit_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expired_o  (tmr_exp)
    );

    always_comb begin
        state_d     = state_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        commit_d    = 1'b0;
        frame_err_d = 1'b0;
        tmr_load    = 1'b0;
        tmr_val     = BIT_LOAD;

        unique case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    tmr_load = 1'b1;
                    tmr_val  = HALF_LOAD;
                    state_d  = S_START;
                end
            end

            S_START: begin
                if (tmr_exp) begin
                    if (rx_s_q) begin
                        state_d = S_IDLE;
                    end else begin
                        tmr_load  = 1'b1;
                        bit_idx_d = '0;
                        state_d   = S_DATA;
                    end
                end
            end

            S_DATA: begin
                if (tmr_exp) begin
                    shift_d  = {rx_s_q, shift_q[DATA_BITS-1:1]};
                    tmr_load = 1'b1;
                    if (bit_idx_q == LAST_IDX) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end

            // Leaving at the stop-bit midpoint rearms half a bit early for baud skew.
            S_STOP: begin
                if (tmr_exp) begin
                    if (rx_s_q) begin
                        commit_d = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_BREAK;
                    end
                end
            end

            S_BREAK: begin
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // A commit into a full register succeeds only if the old byte leaves the same cycle.
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        if (commit_q) begin
            if (!valid_q || rx_if.ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && rx_if.ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            commit_q    <= 1'b0;
            frame_err_q <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            commit_q    <= commit_d;
            frame_err_q <= frame_err_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx_if.data  = data_q;
    assign rx_if.valid = valid_q;
    assign frame_err   = frame_err_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: table of framed bytes plus hand sequences for latency,
// glitch, break, overrun, and mid-frame reset; delivered bytes go through a scoreboard.
module tb_uart_receiver;

    localparam int BIT = 87;

    logic clk = 1'b0;
    logic rst;
    logic uart_rx;
    logic frame_err;
    logic overrun;

    uart_receiver_if rx_if ();

    uart_receiver #(
        .CLK_CYCLES (BIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .uart_rx   (uart_rx),
        .rx_if     (rx_if),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: records each delivered byte (valid rise or replacement while valid) and pulses.
    logic [7:0] obs_mem [64];
    int         obs_wr    = 0;
    int         rise_n    = 0;
    int         rise_cyc  = 0;
    int         fe_cnt    = 0;
    int         ov_cnt    = 0;
    int         both_cnt  = 0;
    logic       valid_prev = 1'b0;
    logic [7:0] data_prev  = 8'h00;

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_if.valid && (!valid_prev || rx_if.data != data_prev)) begin
                if (obs_wr < 64) obs_mem[obs_wr] = rx_if.data;
                obs_wr = obs_wr + 1;
                if (!valid_prev) begin
                    rise_n   = rise_n + 1;
                    rise_cyc = cyc;
                end
            end
            if (frame_err) fe_cnt = fe_cnt + 1;
            if (overrun) ov_cnt = ov_cnt + 1;
            if (frame_err && overrun) both_cnt = both_cnt + 1;
        end
        valid_prev = rx_if.valid;
        data_prev  = rx_if.data;
    end

    int         n_cmp = 0;
    int         n_err = 0;
    int         obs_rd = 0;
    logic [7:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input int period, input logic stop_lvl);
        uart_rx = 1'b0;
        tick(period);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            tick(period);
        end
        uart_rx = stop_lvl;
        tick(period);
        uart_rx = 1'b1;
    endtask

    task automatic drain();
        while (obs_rd < obs_wr) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_unexpected: got 0x%0h expected no byte", obs_mem[obs_rd]);
            end else begin
                check("sb_byte", {24'h0, obs_mem[obs_rd]}, {24'h0, exp_q.pop_front()});
            end
            obs_rd++;
        end
    endtask

    task automatic consume();
        int n = 0;
        while (!rx_if.valid && n < 2000) begin
            tick(1);
            n++;
        end
        check("valid_before_consume", rx_if.valid, 1);
        rx_if.ready = 1'b1;
        tick(1);
        rx_if.ready = 1'b0;
        check("ready_clears_valid", rx_if.valid, 0);
        drain();
    endtask

    typedef struct {
        logic [7:0] dat;
        int         period;
        logic       stop_lvl;
        logic       exp_valid;
        int         exp_fe;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int fe0, ov0, r0, start1, lat, e_cyc, unstable, n;
        logic [7:0] d_hold;

        vecs[0] = '{dat: 8'hA5, period: BIT, stop_lvl: 1'b1, exp_valid: 1'b1, exp_fe: 0};
        vecs[1] = '{dat: 8'h55, period: 84,  stop_lvl: 1'b1, exp_valid: 1'b1, exp_fe: 0};
        vecs[2] = '{dat: 8'h55, period: 90,  stop_lvl: 1'b1, exp_valid: 1'b1, exp_fe: 0};
        vecs[3] = '{dat: 8'h00, period: BIT, stop_lvl: 1'b1, exp_valid: 1'b1, exp_fe: 0};
        vecs[4] = '{dat: 8'hFF, period: BIT, stop_lvl: 1'b1, exp_valid: 1'b1, exp_fe: 0};
        vecs[5] = '{dat: 8'hC3, period: BIT, stop_lvl: 1'b0, exp_valid: 1'b0, exp_fe: 1};

        rst         = 1'b1;
        uart_rx     = 1'b1;
        rx_if.ready = 1'b0;
        tick(5);
        check("rst_valid", rx_if.valid, 0);
        check("rst_data", {24'h0, rx_if.data}, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun", overrun, 0);
        rst = 1'b0;
        tick(20);
        check("no_false_start", rx_if.valid, 0);

        // Ready while empty is ignored.
        rx_if.ready = 1'b1;
        tick(3);
        rx_if.ready = 1'b0;
        check("ready_when_empty", rx_if.valid, 0);

        // 0x41: latency, hold with ready low, then consume.
        exp_q.push_back(8'h41);
        r0     = rise_n;
        start1 = cyc + 1;
        send(8'h41, BIT, 1'b1);
        check("lat_rose_once", rise_n - r0, 1);
        lat = rise_cyc - start1;
        check("lat_in_window", (lat >= 828 && lat <= 830), 1);
        if (!(lat >= 828 && lat <= 830)) $display("  latency measured %0d", lat);
        check("first_data", {24'h0, rx_if.data}, 32'h41);
        unstable = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (rx_if.valid !== 1'b1 || rx_if.data !== 8'h41) unstable++;
        end
        check("hold_stable", unstable, 0);
        consume();
        check("data_holds_after_pop", {24'h0, rx_if.data}, 32'h41);

        // 30-cycle low glitch on idle line.
        fe0 = fe_cnt;
        uart_rx = 1'b0;
        tick(30);
        uart_rx = 1'b1;
        tick(200);
        check("glitch_no_valid", rx_if.valid, 0);
        check("glitch_no_fe", fe_cnt - fe0, 0);

        for (int i = 0; i < 6; i++) begin
            fe0 = fe_cnt;
            ov0 = ov_cnt;
            if (vecs[i].exp_valid) exp_q.push_back(vecs[i].dat);
            send(vecs[i].dat, vecs[i].period, vecs[i].stop_lvl);
            tick(20);
            check($sformatf("vec%0d_valid", i), rx_if.valid, vecs[i].exp_valid);
            check($sformatf("vec%0d_fe", i), fe_cnt - fe0, vecs[i].exp_fe);
            check($sformatf("vec%0d_ov", i), ov_cnt - ov0, 0);
            if (vecs[i].exp_valid) consume();
            else tick(10);
        end

        // 0x3C with low stop bit and a held-low line.
        fe0 = fe_cnt;
        send(8'h3C, BIT, 1'b0);
        uart_rx = 1'b0;
        tick(2000);
        check("break_one_fe", fe_cnt - fe0, 1);
        check("break_no_valid", rx_if.valid, 0);
        uart_rx = 1'b1;
        tick(50);
        exp_q.push_back(8'h5A);
        send(8'h5A, BIT, 1'b1);
        tick(20);
        check("after_break_data", {24'h0, rx_if.data}, 32'h5A);
        consume();

        // Back-to-back with ready low: second byte dropped.
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        exp_q.push_back(8'h11);
        send(8'h11, BIT, 1'b1);
        send(8'h22, BIT, 1'b1);
        tick(20);
        check("ovr_pulse", ov_cnt - ov0, 1);
        check("ovr_no_fe", fe_cnt - fe0, 0);
        check("ovr_valid", rx_if.valid, 1);
        check("ovr_data_kept", {24'h0, rx_if.data}, 32'h11);
        consume();

        // Back-to-back with ready only in the second commit cycle.
        ov0 = ov_cnt;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        r0     = rise_n;
        start1 = cyc + 1;
        fork
            begin
                send(8'h11, BIT, 1'b1);
                send(8'h22, BIT, 1'b1);
            end
            begin
                n = 0;
                while (rise_n == r0 && n < 2000) begin
                    tick(1);
                    n++;
                end
                check("replace_first_rise", (rise_n != r0), 1);
                e_cyc = start1 + 10 * BIT + (rise_cyc - start1);
                n = 0;
                while (cyc < e_cyc - 1 && n < 2000) begin
                    tick(1);
                    n++;
                end
                rx_if.ready = 1'b1;
                tick(1);
                rx_if.ready = 1'b0;
            end
        join
        tick(20);
        check("replace_data", {24'h0, rx_if.data}, 32'h22);
        check("replace_valid", rx_if.valid, 1);
        check("replace_no_ovr", ov_cnt - ov0, 0);
        consume();

        // Reset during bit 4 of 0xFF.
        fe0    = fe_cnt;
        ov0    = ov_cnt;
        d_hold = rx_if.data;
        check("pre_reset_data_nonzero", (d_hold != 8'h00), 1);
        fork
            send(8'hFF, BIT, 1'b1);
            begin
                tick(2 + BIT / 2 + 4 * BIT + 20);
                rst = 1'b1;
                #1;
                check("midrst_valid", rx_if.valid, 0);
                check("midrst_data", {24'h0, rx_if.data}, 0);
                check("midrst_fe", frame_err, 0);
                check("midrst_ov", overrun, 0);
            end
        join
        tick(5);
        rst = 1'b0;
        tick(20);
        check("midrst_no_pulses", (fe_cnt - fe0) + (ov_cnt - ov0), 0);
        check("midrst_no_valid", rx_if.valid, 0);
        exp_q.push_back(8'h81);
        send(8'h81, BIT, 1'b1);
        tick(20);
        check("after_rst_data", {24'h0, rx_if.data}, 32'h81);
        consume();

        tick(10);
        drain();
        check("sb_all_delivered", exp_q.size(), 0);
        check("fe_ov_exclusive", both_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
